// File: rtl/fwd_regfile_pkg.sv
// Shared definitions for the forwarding register file: state encoding and default widths.
package fwd_regfile_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NRD_DEF    = 2;
    localparam int NSTG_DEF   = 3;

    typedef enum logic {INIT, RUN} state_e;
endpackage

// File: rtl/fwd_regfile_mux.sv
// NSTG-way priority select: lowest stage index wins, then the write port, then stored data.
module fwd_mux #(
    parameter int DATA_W = 32,
    parameter int NSTG   = 3
) (
    input  logic [NSTG-1:0]        stg_hit,
    input  logic [NSTG*DATA_W-1:0] stg_data,
    input  logic                   wr_hit,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic [DATA_W-1:0]      arr_data,
    output logic [DATA_W-1:0]      q
);
    always_comb begin
        q = arr_data;
        if (wr_hit) q = wr_data;
        // Walk oldest to youngest so the youngest matching stage overrides.
        for (int s = NSTG - 1; s >= 0; s--) begin
            if (stg_hit[s]) q = stg_data[s*DATA_W +: DATA_W];
        end
    end
endmodule

// File: rtl/fwd_regfile.sv
// GPR + HI/LO register file with per-stage forwarding, long-latency scoreboard and
// a post-reset zeroing sweep that holds the block not-ready until every entry is cleared.
module fwd_regfile
    import fwd_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NRD    = NRD_DEF,
    parameter int NSTG   = NSTG_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   ready,
    input  logic [NRD*ADDR_W-1:0]  rd_addr,
    output logic [NRD*DATA_W-1:0]  rd_data,
    output logic [NRD-1:0]         rd_stall,
    output logic [DATA_W-1:0]      hi_rdata,
    output logic [DATA_W-1:0]      lo_rdata,
    output logic                   hilo_stall,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [DATA_W-1:0]      wdata,
    input  logic                   hi_we,
    input  logic [DATA_W-1:0]      hi_wdata,
    input  logic                   lo_we,
    input  logic [DATA_W-1:0]      lo_wdata,
    input  logic [NSTG-1:0]        fwd_we,
    input  logic [NSTG*ADDR_W-1:0] fwd_waddr,
    input  logic [NSTG*DATA_W-1:0] fwd_wdata,
    input  logic [NSTG-1:0]        fwd_hi_we,
    input  logic [NSTG-1:0]        fwd_lo_we,
    input  logic [NSTG*DATA_W-1:0] fwd_hi_wdata,
    input  logic [NSTG*DATA_W-1:0] fwd_lo_wdata,
    input  logic                   lock_valid,
    input  logic [ADDR_W-1:0]      lock_addr,
    input  logic                   lock_hilo
);
    localparam int NREG = 2 ** ADDR_W;

    state_e              state;
    logic [ADDR_W-1:0]   cnt;
    logic [NREG-1:0]     pend, pend_nxt;
    logic                hilo_pend, hilo_nxt;
    logic [DATA_W-1:0]   mem [NREG];
    logic [DATA_W-1:0]   hi_q, lo_q, hi_fwd, lo_fwd;

    // Set wins over clear so an op issued in the same cycle as an older write stays pending.
    always_comb begin
        pend_nxt = pend;
        if (we && waddr != '0) pend_nxt[waddr] = 1'b0;
        if (lock_valid && !lock_hilo && lock_addr != '0) pend_nxt[lock_addr] = 1'b1;
    end

    assign hilo_nxt = (hilo_pend && !hi_we && !lo_we) || (lock_valid && lock_hilo);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            cnt       <= '0;
            ready     <= 1'b0;
            pend      <= '0;
            hilo_pend <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == ADDR_W'(NREG - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    pend      <= pend_nxt;
                    hilo_pend <= hilo_nxt;
                end
                default: state <= INIT;
            endcase
        end
    end

    // Storage carries no reset; the sweep defines its contents.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                mem[cnt] <= '0;
                if (cnt == '0) begin
                    hi_q <= '0;
                    lo_q <= '0;
                end
            end else begin
                if (we && waddr != '0) mem[waddr] <= wdata;
                if (hi_we) hi_q <= hi_wdata;
                if (lo_we) lo_q <= lo_wdata;
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [NSTG-1:0]   hit;
        logic [DATA_W-1:0] q;
        logic              wr_hit;

        assign ra     = rd_addr[i*ADDR_W +: ADDR_W];
        assign wr_hit = we && (waddr == ra);

        always_comb begin
            hit = '0;
            for (int s = 0; s < NSTG; s++) begin
                hit[s] = fwd_we[s] && (fwd_waddr[s*ADDR_W +: ADDR_W] == ra);
            end
        end

        fwd_mux #(.DATA_W(DATA_W), .NSTG(NSTG)) u_mux (
            .stg_hit  (hit),
            .stg_data (fwd_wdata),
            .wr_hit   (wr_hit),
            .wr_data  (wdata),
            .arr_data (mem[ra]),
            .q        (q)
        );

        assign rd_data[i*DATA_W +: DATA_W] = (ready && ra != '0) ? q : '0;
        assign rd_stall[i] = !ready || (ra != '0 && pend[ra] && !wr_hit);
    end

    fwd_mux #(.DATA_W(DATA_W), .NSTG(NSTG)) u_hi_mux (
        .stg_hit  (fwd_hi_we),
        .stg_data (fwd_hi_wdata),
        .wr_hit   (hi_we),
        .wr_data  (hi_wdata),
        .arr_data (hi_q),
        .q        (hi_fwd)
    );

    fwd_mux #(.DATA_W(DATA_W), .NSTG(NSTG)) u_lo_mux (
        .stg_hit  (fwd_lo_we),
        .stg_data (fwd_lo_wdata),
        .wr_hit   (lo_we),
        .wr_data  (lo_wdata),
        .arr_data (lo_q),
        .q        (lo_fwd)
    );

    assign hi_rdata   = ready ? hi_fwd : '0;
    assign lo_rdata   = ready ? lo_fwd : '0;
    assign hilo_stall = !ready || (hilo_pend && !hi_we && !lo_we);
endmodule

// File: tb/tb_fwd_regfile.sv
// Directed bench: stimulus pushes expected observations into a queue, a negedge monitor checks them.
module tb_fwd_regfile;
    localparam int K_RDY = 0, K_D0 = 1, K_S0 = 2, K_D1 = 3, K_S1 = 4, K_HI = 5, K_LO = 6, K_HS = 7;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic ready;
    logic [4:0] ra0, ra1;
    logic [63:0] rd_data;
    logic [1:0] rd_stall;
    logic [31:0] hi_rdata, lo_rdata;
    logic hilo_stall;
    logic we, hi_we, lo_we;
    logic [4:0] waddr;
    logic [31:0] wdata, hi_wdata, lo_wdata;
    logic [2:0] fwe, fhe, fle;
    logic [2:0][4:0] fwa;
    logic [2:0][31:0] fwd, fhd, fld;
    logic lock_valid, lock_hilo;
    logic [4:0] lock_addr;

    exp_t sbq[$];
    exp_t cur;
    logic [31:0] act;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fwd_regfile dut (
        .clk(clk), .rst(rst), .ready(ready),
        .rd_addr({ra1, ra0}), .rd_data(rd_data), .rd_stall(rd_stall),
        .hi_rdata(hi_rdata), .lo_rdata(lo_rdata), .hilo_stall(hilo_stall),
        .we(we), .waddr(waddr), .wdata(wdata),
        .hi_we(hi_we), .hi_wdata(hi_wdata), .lo_we(lo_we), .lo_wdata(lo_wdata),
        .fwd_we(fwe), .fwd_waddr(fwa), .fwd_wdata(fwd),
        .fwd_hi_we(fhe), .fwd_lo_we(fle), .fwd_hi_wdata(fhd), .fwd_lo_wdata(fld),
        .lock_valid(lock_valid), .lock_addr(lock_addr), .lock_hilo(lock_hilo)
    );

    always @(negedge clk) begin
        while (sbq.size() > 0) begin
            cur = sbq.pop_front();
            case (cur.kind)
                K_RDY:   act = {31'b0, ready};
                K_D0:    act = rd_data[31:0];
                K_S0:    act = {31'b0, rd_stall[0]};
                K_D1:    act = rd_data[63:32];
                K_S1:    act = {31'b0, rd_stall[1]};
                K_HI:    act = hi_rdata;
                K_LO:    act = lo_rdata;
                default: act = {31'b0, hilo_stall};
            endcase
            checks++;
            if (act !== cur.val) begin
                failures++;
                $display("FAIL %s: got %h expected %h", cur.name, act, cur.val);
            end
        end
    end

    task automatic expect_v(input string n, input int k, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.kind = k;
        e.val  = v;
        sbq.push_back(e);
    endtask

    task automatic check_now(input string n, input logic [31:0] a, input logic [31:0] v);
        checks++;
        if (a !== v) begin
            failures++;
            $display("FAIL %s: got %h expected %h (immediate)", n, a, v);
        end
    endtask

    task automatic wait_ready(input int max_cyc);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < max_cyc) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (ready !== 1'b1) begin
            failures++;
            $display("FAIL wait_ready: ready not seen within %0d cycles", max_cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ra0 = '0; ra1 = '0;
        we = 0; waddr = '0; wdata = '0;
        hi_we = 0; hi_wdata = '0; lo_we = 0; lo_wdata = '0;
        fwe = '0; fwa = '0; fwd = '0;
        fhe = '0; fhd = '0; fle = '0; fld = '0;
        lock_valid = 0; lock_addr = '0; lock_hilo = 0;
    endtask

    // Called in the first cycle after reset deassertion; ends in the first ready cycle.
    task automatic sweep(input bit poke);
        for (int k = 0; k < 32; k++) begin
            ra0 = 5'd5;
            expect_v("init_ready_low", K_RDY, 0);
            if (k == 0) begin
                expect_v("init_stall", K_S0, 1);
                expect_v("init_hilo_stall", K_HS, 1);
                expect_v("init_rd_zero", K_D0, 0);
            end
            if (poke && k == 25) begin
                we = 1; waddr = 5'd20; wdata = 32'h2020;
                lock_valid = 1; lock_addr = 5'd21;
                fwe[0] = 1; fwa[0] = 5'd5; fwd[0] = 32'hFACE;
                hi_we = 1; hi_wdata = 32'h4444;
                expect_v("init_fwd_masked", K_D0, 0);
                expect_v("init_hi_masked", K_HI, 0);
            end
            step();
            idle();
        end
        expect_v("ready_after_sweep", K_RDY, 1);
    endtask

    initial begin
        idle();
        rst = 1;
        step();
        step();
        expect_v("reset_ready", K_RDY, 0);
        check_now("reset_ready_now", {31'b0, ready}, 0);
        step();
        rst = 0;
        sweep(0);
        check_now("ready_after_sweep_now", {31'b0, ready}, 1);
        ra0 = 5'd1; ra1 = 5'd0;
        expect_v("run_r1_zero", K_D0, 0);
        expect_v("run_r1_nostall", K_S0, 0);
        expect_v("run_hi_zero", K_HI, 0);
        expect_v("run_lo_zero", K_LO, 0);
        expect_v("run_hilo_nostall", K_HS, 0);
        step();

        // Forwarding priority on r5.
        ra0 = 5'd5; we = 1; waddr = 5'd5; wdata = 32'h1234;
        expect_v("wport_bypass", K_D0, 32'h1234);
        step(); idle();
        ra0 = 5'd5; ra1 = 5'd0;
        fwe = 3'b111;
        fwa[0] = 5'd5; fwd[0] = 32'hAAAA;
        fwa[1] = 5'd0; fwd[1] = 32'hBEEF;
        fwa[2] = 5'd5; fwd[2] = 32'h5555;
        we = 1; waddr = 5'd0; wdata = 32'hCAFE;
        expect_v("fwd_stage0_wins", K_D0, 32'hAAAA);
        expect_v("r0_reads_zero", K_D1, 0);
        step();
        fwe = 3'b100; we = 0;
        expect_v("fwd_stage2", K_D0, 32'h5555);
        step();
        fwe = 3'b000;
        expect_v("stored_r5", K_D0, 32'h1234);
        step(); idle();

        // Lock r7 then resolve via the write port.
        ra0 = 5'd7; lock_valid = 1; lock_addr = 5'd7;
        expect_v("lock_cycle_nostall", K_S0, 0);
        step(); idle();
        ra0 = 5'd7;
        expect_v("r7_stall", K_S0, 1);
        step();
        we = 1; waddr = 5'd7; wdata = 32'h77;
        expect_v("r7_wr_unstall", K_S0, 0);
        expect_v("r7_wr_data", K_D0, 32'h77);
        step(); idle();
        ra0 = 5'd7;
        expect_v("r7_cleared", K_S0, 0);
        expect_v("r7_stored", K_D0, 32'h77);
        step(); idle();

        // Forwarding does not clear a pending bit.
        lock_valid = 1; lock_addr = 5'd9;
        step(); idle();
        ra0 = 5'd9; fwe[0] = 1; fwa[0] = 5'd9; fwd[0] = 32'h99;
        expect_v("r9_fwd_data", K_D0, 32'h99);
        expect_v("r9_fwd_still_stall", K_S0, 1);
        step(); idle();
        ra0 = 5'd9;
        expect_v("r9_stall_persists", K_S0, 1);
        step(); idle();

        // Lock and write r3 together; lock r0.
        ra1 = 5'd3; lock_valid = 1; lock_addr = 5'd3;
        we = 1; waddr = 5'd3; wdata = 32'h33;
        expect_v("r3_same_cycle_nostall", K_S1, 0);
        expect_v("r3_same_cycle_data", K_D1, 32'h33);
        step(); idle();
        ra1 = 5'd3;
        expect_v("r3_set_wins", K_S1, 1);
        expect_v("r3_stored", K_D1, 32'h33);
        step(); idle();
        lock_valid = 1; lock_addr = 5'd0; ra1 = 5'd0;
        expect_v("r0_lock_nostall", K_S1, 0);
        step(); idle();
        ra1 = 5'd0;
        expect_v("r0_never_stalls", K_S1, 0);
        expect_v("r0_zero", K_D1, 0);
        step(); idle();

        // HI/LO lock, forwarding and clear.
        lock_valid = 1; lock_hilo = 1;
        expect_v("hilo_lock_cycle", K_HS, 0);
        step(); idle();
        expect_v("hilo_stall", K_HS, 1);
        step();
        fhe[1] = 1; fhd[1] = 32'hDEAD; fle[1] = 1; fld[1] = 32'hBEEF;
        expect_v("hi_fwd", K_HI, 32'hDEAD);
        expect_v("lo_fwd", K_LO, 32'hBEEF);
        expect_v("hilo_fwd_still_stall", K_HS, 1);
        step();
        hi_we = 1; hi_wdata = 32'h1111;
        expect_v("hi_stage_over_wport", K_HI, 32'hDEAD);
        expect_v("hilo_wr_unstall", K_HS, 0);
        step(); idle();
        expect_v("hi_stored", K_HI, 32'h1111);
        expect_v("lo_stored_zero", K_LO, 0);
        expect_v("hilo_cleared", K_HS, 0);
        step();
        fhe = 3'b101; fhd[0] = 32'hA0; fhd[2] = 32'hA2;
        expect_v("hi_stage0_wins", K_HI, 32'hA0);
        step(); idle();

        // Reset in RUN with r3, r9 and HI/LO pending.
        lock_valid = 1; lock_hilo = 1;
        step(); idle();
        expect_v("hilo_pending_pre_rst", K_HS, 1);
        step();
        rst = 1;
        step();
        rst = 0;
        sweep(0);
        ra0 = 5'd9; ra1 = 5'd3;
        expect_v("r9_pend_reset", K_S0, 0);
        expect_v("r3_pend_reset", K_S1, 0);
        expect_v("hilo_pend_reset", K_HS, 0);
        step(); idle();
        ra0 = 5'd5; ra1 = 5'd7;
        expect_v("r5_swept", K_D0, 0);
        expect_v("r7_swept", K_D1, 0);
        expect_v("hi_swept", K_HI, 0);
        step(); idle();

        // Reset again while the sweep is at cnt=10.
        rst = 1;
        step();
        rst = 0;
        for (int k = 0; k < 10; k++) begin
            expect_v("pre_abort_ready_low", K_RDY, 0);
            step();
        end
        rst = 1;
        expect_v("abort_ready_low", K_RDY, 0);
        step();
        rst = 0;
        sweep(1);
        ra0 = 5'd20; ra1 = 5'd21;
        expect_v("init_write_ignored", K_D0, 0);
        expect_v("init_lock_ignored", K_S1, 0);
        expect_v("init_hi_write_ignored", K_HI, 0);
        step(); idle();
        step();
        wait_ready(40);
        @(negedge clk);
        #1;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard: %0d expectations left unchecked", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fwd_regfile.md
FWD_REGFILE -- requirements
Module: fwd_regfile

Interface
REQ-001 SHALL have parameters: DATA_W, default 32, data width; ADDR_W, default 5, register address width (NREG = 2**ADDR_W); NRD, default 2, read port count; NSTG, default 3, forwarding stage count (index 0 = youngest).
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1, single clock, all state on rising edge.
- rst, in, 1, synchronous active-high reset.
- ready, out, 1, init sweep done; block accepts writes and locks.
- rd_addr, in, NRD*ADDR_W, packed read addresses, port i at slice i.
- rd_data, out, NRD*DATA_W, packed read data.
- rd_stall, out, NRD, per-port pending-operand stall.
- hi_rdata, out, DATA_W, forwarded HI value.
- lo_rdata, out, DATA_W, forwarded LO value.
- hilo_stall, out, 1, HI/LO pending.
- we / waddr / wdata, in, 1 / ADDR_W / DATA_W, architectural GPR write.
- hi_we / hi_wdata, in, 1 / DATA_W, HI write.
- lo_we / lo_wdata, in, 1 / DATA_W, LO write.
- fwd_we, in, NSTG, per-stage GPR write valid.
- fwd_waddr, in, NSTG*ADDR_W, per-stage destination.
- fwd_wdata, in, NSTG*DATA_W, per-stage GPR result.
- fwd_hi_we / fwd_lo_we, in, NSTG each, per-stage HI/LO write valid.
- fwd_hi_wdata / fwd_lo_wdata, in, NSTG*DATA_W each, per-stage HI/LO results (independent, so a multiply writes both).
- lock_valid, in, 1, issue of long-latency op.
- lock_addr, in, ADDR_W, its GPR destination.
- lock_hilo, in, 1, op targets HI/LO instead of a GPR.

Function
REQ-003 Read port i: address 0 SHALL return 0; else lowest-index stage s with fwd_we[s] and matching fwd_waddr; else write port if we and waddr match; else array; purely combinational.
REQ-004 hi_rdata SHALL resolve by same priority over fwd_hi_we, then hi_we, then stored HI; lo_rdata likewise.
REQ-005 GPR write SHALL take effect at the rising edge when we=1, ready=1 and waddr!=0; HI/LO writes independent and simultaneous.
REQ-006 States SHALL be INIT and RUN; INIT writes zero to register cnt per cycle, cnt 0..NREG-1, plus HI/LO on cnt=0, then moves to RUN; ready=1 only in RUN.
REQ-007 INIT SHALL last exactly NREG cycles after reset deassertion; ready rises on the following edge.
REQ-008 In INIT: rd_data and hi/lo_rdata SHALL be 0, rd_stall and hilo_stall all 1, writes and locks ignored.
REQ-009 A pending bit per GPR SHALL be set by lock_valid with lock_hilo=0 (address 0 ignored) and cleared by a write-port write to that address.
REQ-010 A single HI/LO pending bit SHALL be set by lock_valid with lock_hilo=1 and cleared by hi_we or lo_we.
REQ-011 Set and clear of the same bit in one cycle SHALL leave it set.
REQ-012 rd_stall[i] SHALL be 1 when rd_addr!=0, the pending bit is set and the write port is not writing that address this cycle; address 0 never stalls.
REQ-013 hilo_stall SHALL be 1 when HI/LO pending and neither hi_we nor lo_we is asserted.
REQ-014 Forwarding SHALL NOT clear pending bits; only the write port clears.

Reset
REQ-015 rst SHALL force INIT, cnt=0, ready=0, all pending bits 0, from any state including mid-sweep; array contents are defined only after the sweep.

Structure
REQ-016 Shared package SHALL hold state enum (INIT, RUN) and default width constants; module parameters override.
REQ-017 One sub-module fwd_mux SHALL be used: NSTG-way priority select, instantiated per read port and for HI and LO.

Verification
REQ-018 Reset then idle: ready=0 for 32 cycles, 1 on the 33rd; all reads 0.
REQ-019 Stages 0 and 2 both target r5 (0xAAAA, 0x5555) with r5=0x1234 stored: rd_data=0xAAAA; remove stage 0 -> 0x5555; remove both -> 0x1234.
REQ-020 Lock r7; read r7: rd_stall=1; write r7=0x77 same cycle: rd_stall=0, data 0x77; next cycle stall 0.
REQ-021 Lock r3 and write r3 same cycle: pending stays 1; lock r0: never stalls.
REQ-022 lock_hilo, then fwd_hi_we stage1=0xDEAD: hi_rdata=0xDEAD, hilo_stall=1; hi_we=1: stall cleared.
REQ-023 rst asserted mid-INIT at cnt=10 and mid-RUN with pending bits set: both return to full 32-cycle INIT, no stalls after ready.
